axi_write_path_lock: RTL

- Write-channel ownership tracker sitting directly downstream of the AW arbiter/decoder in the AXI crossbar.
- On each accepted AW handshake it latches the granted master/slave pair and burst length.
- It then steers the W channel for exactly that pair until WLAST, steers the B channel until the B handshake, and blocks further AW grants while a write is in flight.
- One outstanding write crossbar-wide.

---
 rtl/axi_write_path_lock_if.sv | 40 ++++
 rtl/axi_write_path_lock.sv | 136 +++++++++++++
 2 files changed

// File: rtl/axi_write_path_lock_if.sv
// Crossbar-side view of the write path: arbiter/decoder selections, the muxed
// handshakes of the owning pair, and the steering/blocking controls back out.
interface axi_write_path_lock_if #(
  parameter int NUM_M    = 3,
  parameter int NUM_S    = 8,
  parameter int LEN_BITS = 4
);
  localparam int MW = $clog2(NUM_M);
  localparam int SW = $clog2(NUM_S + 1);

  logic [MW-1:0]       aw_sel_m;
  logic [SW-1:0]       aw_sel_s;
  logic                AWVALID_sel;
  logic                AWREADY_sel;
  logic [LEN_BITS-1:0] AWLEN_sel;
  logic                WVALID_sel;
  logic                WREADY_sel;
  logic                WLAST_sel;
  logic                BVALID_sel;
  logic                BREADY_sel;
  logic                aw_block;
  logic                w_route_en;
  logic                b_route_en;
  logic [MW-1:0]       w_m;
  logic [SW-1:0]       w_s;
  logic                len_err;
  logic                txn_done;

  modport slave (
    input  aw_sel_m, aw_sel_s, AWVALID_sel, AWREADY_sel, AWLEN_sel,
    input  WVALID_sel, WREADY_sel, WLAST_sel, BVALID_sel, BREADY_sel,
    output aw_block, w_route_en, b_route_en, w_m, w_s, len_err, txn_done
  );

  modport master (
    output aw_sel_m, aw_sel_s, AWVALID_sel, AWREADY_sel, AWLEN_sel,
    output WVALID_sel, WREADY_sel, WLAST_sel, BVALID_sel, BREADY_sel,
    input  aw_block, w_route_en, b_route_en, w_m, w_s, len_err, txn_done
  );
endinterface

// File: rtl/axi_write_path_lock.sv
// Single-outstanding AXI write ownership tracker: locks W/B steering to the
// granted master/slave pair. Define WPATH_TIMEOUT_EN to add a 4095-cycle watchdog.
module axi_write_path_lock #(
  parameter int NUM_M    = 3,
  parameter int NUM_S    = 8,
  parameter int LEN_BITS = 4
) (
  input  logic ACLK,
  input  logic ARESET,
  axi_write_path_lock_if.slave bus
`ifdef WPATH_TIMEOUT_EN
  ,
  output logic timeout_o
`endif
);
  localparam int MW = $clog2(NUM_M);
  localparam int SW = $clog2(NUM_S + 1);

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_e;

  state_e              state_q, state_d;
  logic [MW-1:0]       w_m_q, w_m_d;
  logic [SW-1:0]       w_s_q, w_s_d;
  logic [LEN_BITS-1:0] len_q, len_d;
  logic [LEN_BITS-1:0] beat_cnt_q, beat_cnt_d;
  logic                len_err_q, len_err_d;
  logic                aw_block_q, aw_block_d;
  logic                w_route_q, w_route_d;
  logic                b_route_q, b_route_d;
  logic                txn_done_q, txn_done_d;

  logic aw_hs, w_hs, b_hs, expire;

  assign aw_hs = bus.AWVALID_sel & bus.AWREADY_sel;
  assign w_hs  = bus.WVALID_sel & bus.WREADY_sel;
  assign b_hs  = bus.BVALID_sel & bus.BREADY_sel;

`ifdef WPATH_TIMEOUT_EN
  logic [11:0] wdog_q, wdog_d;
  logic        timeout_q, timeout_d;
  logic        progress;

  // Any handshake in the current phase counts as forward progress.
  assign progress = ((state_q == DATA) && w_hs) || ((state_q == RESP) && b_hs);
  assign expire   = (state_q != IDLE) && (wdog_q == 12'hFFF) && !progress;
  assign timeout_o = timeout_q;
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q    <= IDLE;
      w_m_q      <= '0;
      w_s_q      <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      len_err_q  <= 1'b0;
      aw_block_q <= 1'b0;
      w_route_q  <= 1'b0;
      b_route_q  <= 1'b0;
      txn_done_q <= 1'b0;
`ifdef WPATH_TIMEOUT_EN
      wdog_q     <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      w_m_q      <= w_m_d;
      w_s_q      <= w_s_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      len_err_q  <= len_err_d;
      aw_block_q <= aw_block_d;
      w_route_q  <= w_route_d;
      b_route_q  <= b_route_d;
      txn_done_q <= txn_done_d;
`ifdef WPATH_TIMEOUT_EN
      wdog_q     <= wdog_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (aw_hs) state_d = DATA;
      DATA:    if (w_hs && bus.WLAST_sel) state_d = RESP;
      RESP:    if (b_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (expire) state_d = IDLE;
  end

  // Route/block flags are registered from the next state so they track it exactly.
  always_comb begin
    w_m_d      = w_m_q;
    w_s_d      = w_s_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    len_err_d  = len_err_q;
    if ((state_q == IDLE) && aw_hs) begin
      w_m_d      = bus.aw_sel_m;
      w_s_d      = bus.aw_sel_s;
      len_d      = bus.AWLEN_sel;
      beat_cnt_d = '0;
    end
    if ((state_q == DATA) && w_hs) begin
      if (beat_cnt_q != '1) beat_cnt_d = beat_cnt_q + LEN_BITS'(1);
      if (bus.WLAST_sel ? (beat_cnt_q != len_q) : (beat_cnt_q == len_q))
        len_err_d = 1'b1;
    end
    aw_block_d = (state_d != IDLE);
    w_route_d  = (state_d == DATA);
    b_route_d  = (state_d == RESP);
    txn_done_d = (state_q == RESP) && b_hs;
  end

`ifdef WPATH_TIMEOUT_EN
  always_comb begin
    timeout_d = expire;
    if ((state_d != state_q) || progress) wdog_d = '0;
    else if (state_q != IDLE)             wdog_d = wdog_q + 12'd1;
    else                                  wdog_d = '0;
  end
`endif

  assign bus.aw_block   = aw_block_q;
  assign bus.w_route_en = w_route_q;
  assign bus.b_route_en = b_route_q;
  assign bus.w_m        = w_m_q;
  assign bus.w_s        = w_s_q;
  assign bus.len_err    = len_err_q;
  assign bus.txn_done   = txn_done_q;
endmodule
